imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the combinational instruction memory (9-bit byte address, word-indexed by ra[8:2], 32-bit read data). It owns the PC register and drives the memory read address. It buffers fetched words in a 2-entry queue with a valid/ready handshake toward the IF/ID stage. It handles branch/jump redirects from the execute stage, and halts and resumes fetch on request.

---
 rtl/imem_fetch_ctrl.sv | 85 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and 2-entry fetch queue feeding IF/ID, with redirect and halt control.
module imem_fetch_ctrl #(
  parameter int          INS_ADDRESS = 9,
  parameter int          INS_W       = 32,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   if_valid,
  output logic [INS_W-1:0]       if_instr,
  output logic [INS_ADDRESS-1:0] if_pc,
  input  logic                   if_ready,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  input  logic                   halt_req,
  output logic                   halted,
  output logic                   misalign_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d, pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INS_W-1:0]       ins0_q, ins0_d, ins1_q, ins1_d;
  logic [1:0]             cnt_q, cnt_d, cnt_mid;
  logic                   halted_q, halted_d, mis_q, mis_d, pop, push;
  always_comb begin
    pop     = (cnt_q != 2'd0) && if_ready;
    push    = (state_q == RUN) && !halt_req && !redirect_valid && ((cnt_q != 2'd2) || pop);
    cnt_mid = cnt_q - {1'b0, pop};
    pc0_d   = pop ? pc1_q : pc0_q;
    ins0_d  = pop ? ins1_q : ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    if (push && cnt_mid == 2'd0) begin
      pc0_d  = pc_q;
      ins0_d = imem_rd;
    end
    if (push && cnt_mid != 2'd0) begin
      pc1_d  = pc_q;
      ins1_d = imem_rd;
    end
    cnt_d   = cnt_mid + {1'b0, push};
    pc_d    = push ? pc_q + INS_ADDRESS'(4) : pc_q;
    state_d = (state_q == BOOT) ? RUN : halt_req ? HALT : RUN;
    mis_d   = mis_q;
    // a redirect flushes everything, including any same-cycle push or pop
    if (redirect_valid && state_q != BOOT) begin
      cnt_d   = 2'd0;
      pc_d    = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
      state_d = halt_req ? HALT : RUN;
      mis_d   = mis_q | (redirect_pc[1:0] != 2'b00);
    end
    halted_d = (state_d == HALT) && (cnt_d == 2'd0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= INS_ADDRESS'(RESET_PC);
      cnt_q    <= 2'd0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      ins0_q   <= '0;
      ins1_q   <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      ins0_q   <= ins0_d;
      ins1_q   <= ins1_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end
  assign imem_ra      = pc_q;
  assign if_valid     = cnt_q != 2'd0;
  assign if_pc        = if_valid ? pc0_q : '0;
  assign if_instr     = if_valid ? ins0_q : '0;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_imem_fetch_ctrl;
  logic        clk = 0, reset, if_ready, redirect_valid, halt_req;
  logic [8:0]  imem_ra, if_pc, redirect_pc;
  logic [31:0] imem_rd, if_instr;
  logic        if_valid, halted, misalign_err;
  logic [31:0] mem [0:127];
  int          n_chk = 0, n_fail = 0;
  logic [40:0] mq[$];
  logic [8:0]  mpc, ra_hold;
  bit          mboot, mhalt, mhalted, mmis, armed = 0, m_pop, m_fetch;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_ra(imem_ra), .imem_rd(imem_rd),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;
  assign imem_rd = mem[imem_ra[8:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      mpc = 9'h000; mboot = 1; mhalt = 0; mhalted = 0; mmis = 0; armed = 1;
    end else if (mboot) begin
      mboot = 0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & 9'h1FC;
      if (redirect_pc[1:0] != 2'b00) mmis = 1;
      mhalt = halt_req;
      mhalted = halt_req;
    end else begin
      m_pop = mq.size() > 0 && if_ready;
      m_fetch = !mhalt && !halt_req && (mq.size() < 2 || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_fetch) begin
        mq.push_back({mpc, mem[mpc[8:2]]});
        mpc = mpc + 9'd4;
      end
      mhalt = halt_req;
      mhalted = mhalt && mq.size() == 0;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("m_valid", if_valid, mq.size() != 0);
    chk("m_pc", if_pc, mq.size() != 0 ? mq[0][40:32] : 9'h0);
    chk("m_instr", if_instr, mq.size() != 0 ? mq[0][31:0] : 32'h0);
    chk("m_ra", imem_ra, mpc);
    chk("m_halted", halted, mhalted);
    chk("m_mis", misalign_err, mmis);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0A00_0013 ^ (i << 12);
    mem[0] = 32'h00007033; mem[1] = 32'h00100093; mem[2] = 32'h00200113; mem[21] = 32'h00008413;
    reset = 0; if_ready = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", if_valid, 0); chk("rst_pc", if_pc, 0); chk("rst_instr", if_instr, 0);
    chk("rst_halted", halted, 0); chk("rst_mis", misalign_err, 0); chk("rst_ra", imem_ra, 0);
    reset = 1;
    @(negedge clk); chk("boot_bubble", if_valid, 0);
    @(negedge clk); chk("first_valid", if_valid, 1); chk("first_pc", if_pc, 9'h000); chk("first_ins", if_instr, 32'h00007033);
    @(negedge clk); chk("seq_pc1", if_pc, 9'h004); chk("seq_ins1", if_instr, 32'h00100093);
    if_ready = 0;
    repeat (5) @(negedge clk);
    chk("stall_pc", if_pc, 9'h004); chk("stall_ra", imem_ra, 9'h00C);
    if_ready = 1;
    @(negedge clk); chk("rel_pc8", if_pc, 9'h008); chk("rel_ins8", if_instr, 32'h00200113);
    @(negedge clk); chk("rel_pcC", if_pc, 9'h00C);
    redirect_valid = 1; redirect_pc = 9'h054;
    @(negedge clk); redirect_valid = 0;
    chk("br_flush", if_valid, 0); chk("br_ra", imem_ra, 9'h054);
    @(negedge clk); chk("br_pc", if_pc, 9'h054); chk("br_ins", if_instr, 32'h00008413);
    redirect_valid = 1; redirect_pc = 9'h066;
    @(negedge clk); redirect_valid = 0;
    chk("mis_set", misalign_err, 1); chk("mis_ra", imem_ra, 9'h064);
    repeat (3) @(negedge clk); chk("mis_sticky", misalign_err, 1);
    redirect_valid = 1; redirect_pc = 9'h1F8;
    @(negedge clk); redirect_valid = 0;
    repeat (2) @(negedge clk); chk("wrap_pc", if_pc, 9'h1FC); chk("wrap_ra", imem_ra, 9'h000);
    @(negedge clk); chk("wrap_head", if_pc, 9'h000); chk("wrap_ins", if_instr, 32'h00007033);
    if_ready = 0;
    @(negedge clk); halt_req = 1;
    @(negedge clk); ra_hold = imem_ra; chk("halt_ra", imem_ra, 9'h008); chk("halt_q", if_pc, 9'h000);
    if_ready = 1;
    @(negedge clk); chk("halt_pop1", if_pc, 9'h004); chk("halt_nh", halted, 0); chk("halt_ra1", imem_ra, ra_hold);
    @(negedge clk); chk("halted", halted, 1); chk("halt_empty", if_valid, 0);
    repeat (2) @(negedge clk); chk("halt_ra2", imem_ra, 9'h008); chk("halted2", halted, 1);
    halt_req = 0;
    @(negedge clk); chk("resume_nh", halted, 0); chk("resume_v", if_valid, 0);
    @(negedge clk); chk("resume_pc", if_pc, 9'h008); chk("resume_ins", if_instr, 32'h00200113);
    halt_req = 1;
    repeat (2) @(negedge clk); reset = 0;
    @(negedge clk);
    chk("rst2_valid", if_valid, 0); chk("rst2_halted", halted, 0); chk("rst2_mis", misalign_err, 0);
    chk("rst2_ra", imem_ra, 0); chk("rst2_pc", if_pc, 0);
    reset = 1; halt_req = 0; redirect_valid = 1; redirect_pc = 9'h100;
    @(negedge clk); redirect_valid = 0; chk("boot2_v", if_valid, 0); chk("boot2_ra", imem_ra, 9'h000);
    @(negedge clk); chk("boot2_pc", if_pc, 9'h000); chk("boot2_ins", if_instr, 32'h00007033);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
